lap_timer: RTL

LAP_TIMER -- requirements
Module: lap_timer

---
 rtl/watch_pkg.sv | 30 +++
 rtl/mod_digit.sv | 61 ++++++
 rtl/lap_timer.sv | 105 ++++++++++
 3 files changed

// File: rtl/watch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : watch_pkg
// Description : Shared digit width, default MM:SS.mmm radix vector, count
//               direction type and digit clamp helper for the watch blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package watch_pkg;

    localparam int DIGIT_W           = 4;
    localparam int STOPWATCH_NDIGITS = 7;

    // MSB first: tens of minutes, minutes, tens of seconds, seconds, ms x3
    localparam logic [DIGIT_W*STOPWATCH_NDIGITS-1:0] STOPWATCH_RADIX =
        {4'd6, 4'd10, 4'd6, 4'd10, 4'd10, 4'd10, 4'd10};

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic logic [DIGIT_W-1:0] digit_clamp(
        input logic [DIGIT_W-1:0] value,
        input logic [DIGIT_W-1:0] modulus
    );
        return (value >= modulus) ? (modulus - 4'd1) : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_digit.sv
`default_nettype none
// ============================================================================
// Module      : mod_digit
// Description : One modulo-N BCD digit with up/down stepping, ripple enable
//               out, and clamped synchronous load.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_digit
    import watch_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MODULUS = 4'd10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [DIGIT_W-1:0] preset_i,
    input  dir_e               dir_i,
    input  logic               step_i,
    output logic [DIGIT_W-1:0] digit_o,
    output logic [DIGIT_W-1:0] digit_next_o,
    output logic               step_o
);

    localparam logic [DIGIT_W-1:0] C_MAX = MODULUS - 4'd1;

    logic [DIGIT_W-1:0] digit_q;
    logic [DIGIT_W-1:0] digit_d;
    logic               w_at_limit;

    // Limit is the value that wraps and passes the step on to the next digit
    assign w_at_limit = (dir_i == DIR_DOWN) ? (digit_q == '0) : (digit_q == C_MAX);
    assign step_o     = step_i & w_at_limit;

    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = digit_clamp(preset_i, MODULUS);
        end else if (step_i) begin
            if (w_at_limit) begin
                digit_d = (dir_i == DIR_DOWN) ? C_MAX : '0;
            end else if (dir_i == DIR_DOWN) begin
                digit_d = digit_q - 4'd1;
            end else begin
                digit_d = digit_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o      = digit_q;
    assign digit_next_o = digit_d;

endmodule
`default_nettype wire

// File: rtl/lap_timer.sv
`default_nettype none
// ============================================================================
// Module      : lap_timer
// Description : BCD stopwatch / countdown timer with lap freeze, sticky wrap
//               flag and countdown-done flag.
// Revision    : 1.0 - initial release
// ============================================================================
module lap_timer
    import watch_pkg::*;
#(
    parameter int                         NDIGITS = 7,
    parameter logic [DIGIT_W*NDIGITS-1:0] RADIX   = STOPWATCH_RADIX
) (
    input  logic                       clk_1Khz,
    input  logic                       rst,
    input  logic                       tick,
    input  logic                       EN,
    input  logic                       load,
    input  logic                       down,
    input  logic                       lap,
    input  logic [DIGIT_W*NDIGITS-1:0] preset,
    output logic [DIGIT_W*NDIGITS-1:0] count,
    output logic [DIGIT_W*NDIGITS-1:0] dispbuf,
    output logic                       lap_valid,
    output logic                       done,
    output logic                       ovf
);

    localparam int C_W = DIGIT_W * NDIGITS;

    logic [C_W-1:0]   w_count;
    logic [C_W-1:0]   w_count_next;
    logic [NDIGITS:0] w_carry;
    dir_e             w_dir;
    logic             w_all_zero;
    logic             w_wrap;
    logic             w_lap_rise;

    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             lap_prev_q;
    logic             lap_valid_q, lap_valid_d;
    logic [C_W-1:0]   lap_reg_q, lap_reg_d;

    assign w_dir      = dir_e'(down);
    assign w_all_zero = (w_count == '0);

    // Countdown parks at zero: suppress the step instead of letting it borrow
    assign w_carry[0] = EN & tick & ~load & ~((w_dir == DIR_DOWN) & w_all_zero);

    generate
        for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
            mod_digit #(
                .MODULUS (RADIX[i*DIGIT_W +: DIGIT_W])
            ) u_digit (
                .clk_i        (clk_1Khz),
                .rst_ni       (rst),
                .load_i       (load),
                .preset_i     (preset[i*DIGIT_W +: DIGIT_W]),
                .dir_i        (w_dir),
                .step_i       (w_carry[i]),
                .digit_o      (w_count[i*DIGIT_W +: DIGIT_W]),
                .digit_next_o (w_count_next[i*DIGIT_W +: DIGIT_W]),
                .step_o       (w_carry[i+1])
            );
        end
    endgenerate

    assign w_wrap     = (w_dir == DIR_UP) & w_carry[NDIGITS];
    assign w_lap_rise = lap & ~lap_prev_q;

    always_comb begin
        ovf_d       = load ? 1'b0 : (ovf_q | w_wrap);
        done_d      = (w_dir == DIR_DOWN) & (w_count_next == '0);
        lap_valid_d = lap_valid_q ^ w_lap_rise;
        lap_reg_d   = lap_reg_q;
        if (w_lap_rise && !lap_valid_q) begin
            lap_reg_d = w_count;
        end
    end

    always_ff @(posedge clk_1Khz or negedge rst) begin
        if (!rst) begin
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            lap_prev_q  <= 1'b0;
            lap_valid_q <= 1'b0;
            lap_reg_q   <= '0;
        end else begin
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            lap_prev_q  <= lap;
            lap_valid_q <= lap_valid_d;
            lap_reg_q   <= lap_reg_d;
        end
    end

    assign count     = w_count;
    assign dispbuf   = lap_valid_q ? lap_reg_q : w_count;
    assign lap_valid = lap_valid_q;
    assign done      = done_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire
